// File: rtl/probe_capture.sv
`default_nettype none
// ============================================================================
// Module      : probe_capture
// Description : Multi-channel fixed-point capture recorder. Samples packed
//               probe channels into a circular buffer with decimation and a
//               pre-trigger window, stops on a signed level crossing or a
//               forced trigger, then streams the window out over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module probe_capture #(
    parameter int N_CH     = 2,
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 256,
    parameter int PRE_TRIG = 64,
    parameter int DECIM_W  = 8,
    localparam int c_TW    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH*WIDTH-1:0]   sample_in,
    input  logic                    arm,
    input  logic                    force_trig,
    input  logic [c_TW-1:0]         trig_ch,
    input  logic [WIDTH-1:0]        trig_level,
    input  logic                    trig_fall,
    input  logic [DECIM_W-1:0]      decim,
    output logic                    busy,
    output logic                    trig_seen,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [N_CH*WIDTH-1:0]   rd_data,
    output logic                    rd_last
);

    localparam int c_AW   = $clog2(DEPTH);
    localparam int c_CW   = c_AW + 1;
    localparam int c_POST = DEPTH - PRE_TRIG;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRE     = 3'd1,
        S_ARMED   = 3'd2,
        S_POST    = 3'd3,
        S_READOUT = 3'd4
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [DECIM_W-1:0]      r_dcnt;
    logic [c_AW-1:0]         r_wptr, r_trig_addr, r_raddr;
    logic [c_CW-1:0]         r_cnt, r_icnt;
    logic signed [WIDTH-1:0] r_prev;
    logic                    r_prev_vld, r_force_pend, r_trig_seen;
    logic [N_CH*WIDTH-1:0]   r_mem [DEPTH];
    logic [N_CH*WIDTH-1:0]   r_rdq;
    logic                    r_qv, r_ql;

    logic signed [WIDTH-1:0] w_ch [N_CH];
    logic signed [WIDTH-1:0] w_cur;
    logic                    w_active, w_samp, w_prev_lt, w_cur_lt, w_cross;
    logic                    w_trig, w_pre_done, w_post_done, w_last_xfer;
    logic                    w_a_adv, w_b_adv, w_issue, w_ro_enter;
    logic [c_AW-1:0]         w_trig_base;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign w_ch[g] = sample_in[g*WIDTH +: WIDTH];
    end

    // Select the trigger channel; out-of-range selections fall back to ch0
    always_comb begin
        w_cur = w_ch[0];
        for (int i = 1; i < N_CH; i++) begin
            if (trig_ch == c_TW'(i)) w_cur = w_ch[i];
        end
    end

    assign w_active    = (r_state == S_PRE) || (r_state == S_ARMED) || (r_state == S_POST);
    assign w_samp      = w_active && (r_dcnt == '0);
    assign w_prev_lt   = r_prev < $signed(trig_level);
    assign w_cur_lt    = w_cur < $signed(trig_level);
    assign w_cross     = trig_fall ? (!w_prev_lt && w_cur_lt) : (w_prev_lt && !w_cur_lt);
    assign w_trig      = (r_state == S_ARMED) && w_samp && (r_force_pend || (r_prev_vld && w_cross));
    assign w_pre_done  = (r_state == S_PRE) && w_samp && (r_cnt == c_CW'(PRE_TRIG - 1));
    assign w_post_done = (r_state == S_POST) && w_samp && (r_cnt == c_CW'(c_POST - 1));
    assign w_last_xfer = rd_valid && rd_ready && rd_last;

    // Readout pipeline: RAM read stage feeds the output register stage
    assign w_b_adv     = !rd_valid || rd_ready;
    assign w_a_adv     = !r_qv || w_b_adv;
    assign w_issue     = (r_state == S_READOUT) && (r_icnt != c_CW'(DEPTH)) && w_a_adv;
    assign w_ro_enter  = (r_state != S_READOUT) && (w_state_nxt == S_READOUT);
    // With a single post sample the trigger address is latched on the entry edge
    assign w_trig_base = (r_state == S_ARMED) ? r_wptr : r_trig_addr;

    assign busy      = (r_state != S_IDLE);
    assign trig_seen = r_trig_seen;

    // Next-state decode of the capture controller
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (arm)         w_state_nxt = S_PRE;
            S_PRE:     if (w_pre_done)  w_state_nxt = S_ARMED;
            S_ARMED:   if (w_trig)      w_state_nxt = (c_POST == 1) ? S_READOUT : S_POST;
            S_POST:    if (w_post_done) w_state_nxt = S_READOUT;
            S_READOUT: if (w_last_xfer) w_state_nxt = S_IDLE;
            default:                    w_state_nxt = S_IDLE;
        endcase
    end

    // Controller state, counters, trigger tracking and readout sequencing
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_dcnt       <= '0;
            r_wptr       <= '0;
            r_trig_addr  <= '0;
            r_raddr      <= '0;
            r_cnt        <= '0;
            r_icnt       <= '0;
            r_prev       <= '0;
            r_prev_vld   <= 1'b0;
            r_force_pend <= 1'b0;
            r_trig_seen  <= 1'b0;
            r_qv         <= 1'b0;
            r_ql         <= 1'b0;
            rd_valid     <= 1'b0;
            rd_last      <= 1'b0;
            rd_data      <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (r_state == S_IDLE) begin
                r_dcnt <= '0;
            end else if (w_active) begin
                r_dcnt <= (r_dcnt == decim) ? '0 : r_dcnt + 1'b1;
            end

            if ((r_state == S_IDLE) && arm) begin
                r_wptr     <= '0;
                r_cnt      <= '0;
                r_prev_vld <= 1'b0;
            end else if (w_samp) begin
                r_wptr <= r_wptr + 1'b1;
                if (r_state != S_POST) begin
                    r_prev     <= w_cur;
                    r_prev_vld <= 1'b1;
                end
                if (w_trig) begin
                    r_cnt <= c_CW'(1);
                end else if (w_pre_done) begin
                    r_cnt <= '0;
                end else if (r_state != S_ARMED) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            if (r_state == S_ARMED) begin
                if (w_trig)          r_force_pend <= 1'b0;
                else if (force_trig) r_force_pend <= 1'b1;
            end else begin
                r_force_pend <= 1'b0;
            end

            if (w_trig) begin
                r_trig_addr <= r_wptr;
                r_trig_seen <= 1'b1;
            end else if (w_last_xfer) begin
                r_trig_seen <= 1'b0;
            end

            if (w_ro_enter) begin
                r_raddr <= w_trig_base - c_AW'(PRE_TRIG);
                r_icnt  <= '0;
            end else if (w_issue) begin
                r_raddr <= r_raddr + 1'b1;
                r_icnt  <= r_icnt + 1'b1;
            end

            if (w_a_adv) r_qv <= w_issue;
            if (w_issue) r_ql <= (r_icnt == c_CW'(DEPTH - 1));

            if (w_b_adv) begin
                rd_valid <= r_qv;
                rd_last  <= r_qv && r_ql;
                if (r_qv) rd_data <= r_rdq;
            end
        end
    end

    // Sample buffer: write on sample events, synchronous read for readout
    always_ff @(posedge clk) begin
        if (w_samp && rst) r_mem[r_wptr] <= sample_in;
        if (w_issue)       r_rdq <= r_mem[r_raddr];
    end

endmodule
`default_nettype wire

// File: tb/tb_probe_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_probe_capture
// Description : Directed bench for probe_capture with DEPTH=16, PRE_TRIG=4.
//               A vector table of capture scenarios plus hand-written reset
//               sequences; expected readouts are hand-computed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_probe_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] sample_in = '0;
    logic        arm = 1'b0;
    logic        force_trig = 1'b0;
    logic [0:0]  trig_ch = '0;
    logic [15:0] trig_level = '0;
    logic        trig_fall = 1'b0;
    logic [7:0]  decim = '0;
    logic        busy, trig_seen, rd_valid, rd_last;
    logic        rd_ready = 1'b1;
    logic [31:0] rd_data;

    int n_tests = 0;
    int n_fail  = 0;

    probe_capture #(
        .N_CH(2), .WIDTH(16), .DEPTH(16), .PRE_TRIG(4), .DECIM_W(8)
    ) dut (
        .clk(clk), .rst(rst), .sample_in(sample_in), .arm(arm),
        .force_trig(force_trig), .trig_ch(trig_ch), .trig_level(trig_level),
        .trig_fall(trig_fall), .decim(decim), .busy(busy), .trig_seen(trig_seen),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;       // stimulus pattern
        logic [7:0]  decim;
        logic        tch;
        logic        fall;
        logic [15:0] level;
        int          force_at;   // cycle carrying the force_trig pulse, -1 none
        int          ready_mode; // 0 always ready, 1 toggling
        int          exp_trig_c; // cycle whose edge raises trig_seen
        int          exp_valid_c;// cycle whose edge raises rd_valid
        int          b0;         // checked channel, beat 0
        int          step;       // increment per beat
        int          alt_from;   // beats from here carry alt
        int          alt;
        logic [15:0] other;      // constant on the unchecked channel
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Probe stimulus as a function of cycles since the first sample edge
    function automatic logic [31:0] stim(input int kind, input int c);
        logic [15:0] a, b;
        case (kind)
            2:       begin a = (c < 3) ? 16'(8 + c) : 16'd11; b = 16'h5A5A; end
            4:       begin a = 16'h1234; b = (c < 8) ? 16'd50 : 16'hFF38; end
            default: begin a = 16'(c); b = 16'h5A5A; end
        endcase
        return {b, a};
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int c, beats, first_trig, first_valid, val;
        logic        stall_pend, s_last;
        logic [31:0] s_data, exp_d;
        logic [15:0] e;
        beats = 0; first_trig = -1; first_valid = -1; stall_pend = 1'b0;
        s_last = 1'b0; s_data = '0;
        @(negedge clk);
        trig_ch = v.tch; trig_fall = v.fall; trig_level = v.level; decim = v.decim;
        arm = 1'b1;
        @(posedge clk);
        @(negedge clk);
        arm = 1'b0;
        c = 0;
        sample_in  = stim(v.kind, c);
        force_trig = (c == v.force_at);
        rd_ready   = (v.ready_mode == 0) ? 1'b1 : 1'b1;
        while (beats < 16 && c < 400) begin
            @(posedge clk);
            @(negedge clk);
            if (trig_seen && first_trig < 0) first_trig = c;
            if (rd_valid && first_valid < 0) first_valid = c;
            if (stall_pend) begin
                check({tag, " stall_hold"}, {31'd0, rd_valid, rd_last, rd_data},
                      {31'd0, 1'b1, s_last, s_data});
                stall_pend = 1'b0;
            end
            c++;
            rd_ready = (v.ready_mode == 0) ? 1'b1 : ((c % 2) == 0);
            if (rd_valid && rd_ready) begin
                val   = (beats < v.alt_from) ? v.b0 + v.step * beats : v.alt;
                e     = 16'(val);
                exp_d = v.tch ? {e, v.other} : {v.other, e};
                check($sformatf("%s beat%0d_data", tag, beats), rd_data, exp_d);
                check($sformatf("%s beat%0d_last", tag, beats), rd_last, (beats == 15));
                beats++;
            end else if (rd_valid) begin
                stall_pend = 1'b1;
                s_data = rd_data;
                s_last = rd_last;
            end
            sample_in  = stim(v.kind, c);
            force_trig = (c == v.force_at);
        end
        if (beats < 16) check({tag, " timeout_beats"}, beats, 16);
        @(posedge clk);
        @(negedge clk);
        check({tag, " idle_after_last"}, {rd_valid, busy, trig_seen}, 3'b000);
        check({tag, " trig_cycle"}, first_trig, v.exp_trig_c);
        check({tag, " valid_cycle"}, first_valid, v.exp_valid_c);
        force_trig = 1'b0;
        rd_ready   = 1'b1;
    endtask

    initial begin
        //          kind dec tch fall level   force rdy trig valid b0 step altf alt   other
        vecs[0] = '{1, 8'd0, 1'b0, 1'b0, 16'd10,  -1, 0, 10, 23,  6, 1, 16,    0, 16'h5A5A};
        vecs[1] = '{2, 8'd0, 1'b0, 1'b0, 16'd10,   7, 0,  8, 21, 11, 0, 16,    0, 16'h5A5A};
        vecs[2] = '{1, 8'd2, 1'b0, 1'b0, 16'd30,  -1, 0, 30, 65, 18, 3, 16,    0, 16'h5A5A};
        vecs[3] = '{4, 8'd0, 1'b1, 1'b1, 16'hFF9C, -1, 0, 8, 21, 50, 0,  4, -200, 16'h1234};
        vecs[4] = '{1, 8'd0, 1'b0, 1'b0, 16'd10,  -1, 1, 10, 23,  6, 1, 16,    0, 16'h5A5A};

        // Reset values
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {busy, trig_seen, rd_valid, rd_last, rd_data},
              {4'b0000, 32'h0});
        rst = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Reset in POST discards the capture
        @(negedge clk);
        trig_ch = 1'b0; trig_fall = 1'b0; trig_level = 16'd10; decim = 8'd0;
        arm = 1'b1;
        @(posedge clk);
        @(negedge clk);
        arm = 1'b0;
        for (int c = 0; c < 16; c++) begin
            sample_in = stim(1, c);
            @(posedge clk);
            @(negedge clk);
        end
        check("pre_rst_in_post", {busy, trig_seen, rd_valid}, 3'b110);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_outputs", {busy, trig_seen, rd_valid, rd_last, rd_data},
              {4'b0000, 32'h0});
        rst = 1'b1;
        run_vec(vecs[0], "rearm");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
